// File: rtl/dm_access_unit.sv
// MEM-stage data-memory access unit: drives a word-wide SRAM port with an ack handshake,
// builds store byte lanes, extends load data, and reports misalignment and bus timeouts.
module dm_access_unit #(
  parameter int unsigned AW      = 10,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          dm_wr,
  input  logic          dm_rd,
  input  logic [1:0]    save_type,
  input  logic [2:0]    lext_op,
  input  logic [31:0]   addr,
  input  logic [31:0]   wdata,
  output logic          mem_stall,
  output logic [31:0]   rdata,
  output logic          rdata_valid,
  output logic          misalign,
  output logic          bus_err,
  output logic          sram_en,
  output logic [3:0]    sram_we,
  output logic [AW-1:0] sram_addr,
  output logic [31:0]   sram_wdata,
  input  logic [31:0]   sram_rdata,
  input  logic          sram_ack
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic          store_q;
  logic [1:0]    off_q;
  logic [2:0]    lext_q;

  logic          req;
  logic          acc_byte;
  logic          acc_half;
  logic          aligned;
  logic          start;
  logic [3:0]    we_next;
  logic [31:0]   wdata_next;
  logic [7:0]    ld_byte;
  logic [15:0]   ld_half;
  logic [31:0]   ld_ext;

  // Upper address bits lie outside the SRAM window.
  logic unused_addr;
  assign unused_addr = ^addr[31:AW+2];

  always_comb begin
    req = dm_wr | dm_rd;
    // A simultaneous store and load request is treated as a store.
    if (dm_wr) begin
      acc_byte = (save_type == 2'b10);
      acc_half = (save_type == 2'b01);
    end else begin
      acc_byte = (lext_op == 3'b001) || (lext_op == 3'b010);
      acc_half = (lext_op == 3'b011) || (lext_op == 3'b100);
    end
    aligned = acc_byte | (acc_half & ~addr[0]) | (~acc_byte & ~acc_half & (addr[1:0] == 2'b00));

    we_next    = 4'b0000;
    wdata_next = wdata;
    if (dm_wr) begin
      case (save_type)
        2'b01: begin
          we_next    = addr[1] ? 4'b1100 : 4'b0011;
          wdata_next = {2{wdata[15:0]}};
        end
        2'b10: begin
          we_next    = 4'b0001 << addr[1:0];
          wdata_next = {4{wdata[7:0]}};
        end
        default: we_next = 4'b1111;
      endcase
    end

    start     = (state_q == StIdle) & req & ~rst;
    mem_stall = (state_q == StBusy) | (start & aligned);
    misalign  = start & ~aligned;
  end

  always_comb begin
    ld_byte = sram_rdata[{off_q, 3'b000} +: 8];
    ld_half = off_q[1] ? sram_rdata[31:16] : sram_rdata[15:0];
    case (lext_q)
      3'b001:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b010:  ld_ext = {24'b0, ld_byte};
      3'b011:  ld_ext = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_ext = {16'b0, ld_half};
      default: ld_ext = sram_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      store_q     <= 1'b0;
      off_q       <= 2'b00;
      lext_q      <= 3'b000;
      rdata       <= '0;
      rdata_valid <= 1'b0;
      bus_err     <= 1'b0;
      sram_en     <= 1'b0;
      sram_we     <= '0;
      sram_addr   <= '0;
      sram_wdata  <= '0;
    end else begin
      rdata_valid <= 1'b0;
      bus_err     <= 1'b0;
      case (state_q)
        StIdle: begin
          if (req && aligned) begin
            store_q    <= dm_wr;
            off_q      <= addr[1:0];
            lext_q     <= lext_op;
            sram_addr  <= addr[AW+1:2];
            sram_we    <= we_next;
            sram_wdata <= wdata_next;
            cnt_q      <= '0;
            sram_en    <= 1'b1;
            state_q    <= StBusy;
          end
        end
        StBusy: begin
          if (sram_ack) begin
            sram_en <= 1'b0;
            state_q <= StDone;
            if (!store_q) begin
              rdata       <= ld_ext;
              rdata_valid <= 1'b1;
            end
          end else if (cnt_q == CW'(TIMEOUT)) begin
            sram_en <= 1'b0;
            state_q <= StDone;
            bus_err <= 1'b1;
            if (!store_q) begin
              rdata       <= '0;
              rdata_valid <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_dm_access_unit.sv
// Self-checking bench for dm_access_unit: directed vector table, reset-abort sequence and
// randomized accesses checked against a byte-width based reference model.
module tb_dm_access_unit;

  localparam int unsigned AW      = 10;
  localparam int unsigned TIMEOUT = 15;

  logic          clk = 1'b0;
  logic          rst;
  logic          dm_wr, dm_rd;
  logic [1:0]    save_type;
  logic [2:0]    lext_op;
  logic [31:0]   addr, wdata;
  logic          mem_stall;
  logic [31:0]   rdata;
  logic          rdata_valid, misalign, bus_err;
  logic          sram_en;
  logic [3:0]    sram_we;
  logic [AW-1:0] sram_addr;
  logic [31:0]   sram_wdata, sram_rdata;
  logic          sram_ack;

  int n_tests = 0;
  int n_fail  = 0;

  dm_access_unit #(.AW(AW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .dm_wr(dm_wr), .dm_rd(dm_rd), .save_type(save_type),
    .lext_op(lext_op), .addr(addr), .wdata(wdata), .mem_stall(mem_stall), .rdata(rdata),
    .rdata_valid(rdata_valid), .misalign(misalign), .bus_err(bus_err), .sram_en(sram_en),
    .sram_we(sram_we), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
    .sram_rdata(sram_rdata), .sram_ack(sram_ack)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

  typedef struct {
    string       name;
    logic        wr;
    logic        rd;
    logic [1:0]  st;
    logic [2:0]  lx;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rdat;
    int          waits;   // ack-wait cycles before ack; -1 means never ack
    logic [3:0]  we;
    logic [31:0] ewd;
    logic [31:0] erd;
    logic        mis;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    dm_wr = 1'b0; dm_rd = 1'b0; save_type = 2'b00; lext_op = 3'b000;
    addr = '0; wdata = '0; sram_ack = 1'b0; sram_rdata = '0;
  endtask

  // ---------------- reference model ----------------
  function automatic int acc_bytes(input logic wr, input logic [1:0] st, input logic [2:0] lx);
    if (wr) return (st == 2'b01) ? 2 : (st == 2'b10) ? 1 : 4;
    if (lx == 3'd1 || lx == 3'd2) return 1;
    if (lx == 3'd3 || lx == 3'd4) return 2;
    return 4;
  endfunction

  function automatic vec_t model(input vec_t v);
    vec_t   r = v;
    int     w = acc_bytes(v.wr, v.st, v.lx);
    int     off = int'(v.a[1:0]);
    longint val;
    longint span = longint'(1) << (8 * w);
    r.mis = (off % w) != 0;
    r.we  = '0;
    r.ewd = '0;
    r.erd = '0;
    if (v.wr) begin
      r.we = 4'(((1 << w) - 1) << off);
      for (int i = 0; i < 4; i++) r.ewd[8*i +: 8] = v.wd[8*(i % w) +: 8];
    end else if (v.waits >= 0) begin
      val = (longint'(v.rdat) >> (8 * off)) % span;
      if ((v.lx == 3'd1 || v.lx == 3'd3) && val >= span / 2) val = val - span;
      r.erd = val[31:0];
    end
    return r;
  endfunction

  // ---------------- one full access, checked cycle by cycle ----------------
  task automatic do_access(input vec_t v);
    logic        is_load = !v.wr;
    logic [31:0] exp_addr = 32'((v.a >> 2) % (1 << AW));
    int          stall_cnt = 0;
    int          exp_stall;
    tick();
    dm_wr = v.wr; dm_rd = v.rd; save_type = v.st; lext_op = v.lx;
    addr = v.a; wdata = v.wd; sram_ack = 1'b0; sram_rdata = '0;
    @(negedge clk);
    chk({v.name, " idle misalign"}, 32'(misalign), 32'(v.mis));
    chk({v.name, " idle sram_en"}, 32'(sram_en), 32'd0);
    stall_cnt += int'(mem_stall);
    if (v.mis) begin
      chk({v.name, " idle stall"}, 32'(mem_stall), 32'd0);
      tick();
      idle_inputs();
      @(negedge clk);
      chk({v.name, " after sram_en"}, 32'(sram_en), 32'd0);
      chk({v.name, " after misalign"}, 32'(misalign), 32'd0);
      chk({v.name, " after stall"}, 32'(mem_stall), 32'd0);
      return;
    end
    for (int n = 0; n <= int'(TIMEOUT); n++) begin
      tick();
      sram_ack = (v.waits >= 0) && (n == v.waits);
      sram_rdata = v.rdat;
      @(negedge clk);
      stall_cnt += int'(mem_stall);
      chk({v.name, " busy sram_en"}, 32'(sram_en), 32'd1);
      chk({v.name, " busy sram_we"}, 32'(sram_we), 32'(v.we));
      chk({v.name, " busy sram_addr"}, 32'(sram_addr), exp_addr);
      if (v.wr) chk({v.name, " busy sram_wdata"}, sram_wdata, v.ewd);
      chk({v.name, " busy strobes"}, {30'd0, rdata_valid, bus_err}, 32'd0);
      if (sram_ack) break;
    end
    exp_stall = (v.waits >= 0) ? v.waits + 2 : int'(TIMEOUT) + 2;
    chk({v.name, " stall cycles"}, 32'(stall_cnt), 32'(exp_stall));
    tick();
    sram_ack = 1'b0;
    @(negedge clk);
    chk({v.name, " done stall"}, 32'(mem_stall), 32'd0);
    chk({v.name, " done sram_en"}, 32'(sram_en), 32'd0);
    chk({v.name, " done rdata_valid"}, 32'(rdata_valid), 32'(is_load));
    chk({v.name, " done bus_err"}, 32'(bus_err), 32'(v.waits < 0));
    if (is_load) chk({v.name, " done rdata"}, rdata, v.erd);
    tick();
    idle_inputs();
    @(negedge clk);
    chk({v.name, " post strobes"}, {30'd0, rdata_valid, bus_err}, 32'd0);
    chk({v.name, " post sram_en"}, 32'(sram_en), 32'd0);
    if (is_load) chk({v.name, " post rdata hold"}, rdata, v.erd);
  endtask

  vec_t tbl[9];
  vec_t rv;

  initial begin
    tbl[0] = '{"SB", 1, 0, 2'd2, 3'd0, 32'h6, 32'hA5, 32'h0, 0, 4'b0100, 32'hA5A5A5A5, 32'h0, 0};
    tbl[1] = '{"LB", 0, 1, 2'd0, 3'd1, 32'h3, 32'h0, 32'h80FFFFFF, 2, 4'b0000, 32'h0,
               32'hFFFFFF80, 0};
    tbl[2] = '{"LHU", 0, 1, 2'd0, 3'd4, 32'h2, 32'h0, 32'h80011234, 0, 4'b0000, 32'h0,
               32'h00008001, 0};
    tbl[3] = '{"LH", 0, 1, 2'd0, 3'd3, 32'h2, 32'h0, 32'h80011234, 0, 4'b0000, 32'h0,
               32'hFFFF8001, 0};
    tbl[4] = '{"SW mis", 1, 0, 2'd0, 3'd0, 32'h2, 32'h1234, 32'h0, 0, 4'b0000, 32'h0, 32'h0, 1};
    tbl[5] = '{"LH mis", 0, 1, 2'd0, 3'd3, 32'h1, 32'h0, 32'h0, 0, 4'b0000, 32'h0, 32'h0, 1};
    tbl[6] = '{"LW timeout", 0, 1, 2'd0, 3'd0, 32'h10, 32'h0, 32'hDEADBEEF, -1, 4'b0000, 32'h0,
               32'h0, 0};
    tbl[7] = '{"WR+RD", 1, 1, 2'd0, 3'd0, 32'h8, 32'h12345678, 32'hCAFEF00D, 1, 4'b1111,
               32'h12345678, 32'h0, 0};
    tbl[8] = '{"SH hi", 1, 0, 2'd1, 3'd0, 32'h6, 32'h0000BEEF, 32'h0, 0, 4'b1100, 32'hBEEFBEEF,
               32'h0, 0};

    rst = 1'b1;
    idle_inputs();
    repeat (3) tick();
    @(negedge clk);
    chk("reset outputs", {mem_stall, rdata_valid, misalign, bus_err, sram_en, sram_we}, 9'd0);
    chk("reset rdata", rdata, 32'd0);
    chk("reset sram_addr", 32'(sram_addr), 32'd0);
    chk("reset sram_wdata", sram_wdata, 32'd0);
    tick();
    rst = 1'b0;

    foreach (tbl[i]) do_access(tbl[i]);

    // Reset during the second BUSY cycle of a store abandons it silently.
    tick();
    dm_wr = 1'b1; save_type = 2'b00; addr = 32'h20; wdata = 32'h55AA55AA;
    @(negedge clk);
    chk("rst-abort idle stall", 32'(mem_stall), 32'd1);
    tick();
    @(negedge clk);
    chk("rst-abort busy1 sram_en", 32'(sram_en), 32'd1);
    tick();
    rst = 1'b1;
    idle_inputs();
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst-abort outputs", {mem_stall, rdata_valid, misalign, bus_err, sram_en, sram_we}, 9'd0);
    chk("rst-abort rdata", rdata, 32'd0);
    chk("rst-abort sram_addr", 32'(sram_addr), 32'd0);
    chk("rst-abort sram_wdata", sram_wdata, 32'd0);
    tick();
    @(negedge clk);
    chk("rst-abort idle after", {mem_stall, rdata_valid, bus_err, sram_en}, 4'd0);
    do_access(tbl[1]);

    for (int k = 0; k < 60; k++) begin
      int r;
      rv.name = $sformatf("rand%0d", k);
      rv.wr   = 1'($urandom_range(0, 1));
      rv.rd   = rv.wr ? 1'($urandom_range(0, 1)) : 1'b1;
      rv.st   = 2'($urandom_range(0, 3));
      rv.lx   = 3'($urandom_range(0, 7));
      rv.a    = $urandom;
      rv.wd   = $urandom;
      rv.rdat = $urandom;
      r       = int'($urandom_range(0, 11));
      rv.waits = (r == 0) ? -1 : r % 4;
      do_access(model(rv));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
